// File: rtl/mse_eval_scheduler.sv
// mse_eval_scheduler: sequences one word-length evaluation run per request.
// Optional watchdog on the collect phase is enabled with `define WDOG_EN.
module mse_eval_scheduler #(
    parameter int CFG_W       = 16,
    parameter int SEQ_LEN     = 131072,
    parameter int SETTLE_CYC  = 32,
    parameter int TIMEOUT_CYC = SEQ_LEN + 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CFG_W-1:0] req_cfg,
    input  logic [63:0]      req_thresh,
    output logic [CFG_W-1:0] cfg_out,
    output logic             cfg_load,
    output logic             src_restart,
    output logic             col_start,
    input  logic [63:0]      col_data,
    input  logic             col_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_mse,
    output logic             rsp_pass,
    output logic             rsp_timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        START   = 3'd3,
        COLLECT = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [63:0]   thr_q;
    logic [15:0]   run_cnt;

`ifdef WDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wdog_cnt;
    logic          timeout_q;
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Run sequencer: every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            thr_q       <= '0;
            run_cnt     <= '0;
            req_ready   <= 1'b0;
            cfg_out     <= '0;
            cfg_load    <= 1'b0;
            src_restart <= 1'b0;
            col_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_mse     <= '0;
            rsp_pass    <= 1'b0;
            busy        <= 1'b0;
`ifdef WDOG_EN
            wdog_cnt    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            cfg_load    <= 1'b0;
            src_restart <= 1'b0;
            col_start   <= 1'b0;
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        cfg_out     <= req_cfg;
                        thr_q       <= req_thresh;
                        cfg_load    <= 1'b1;
                        src_restart <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                        col_start <= 1'b1;
                        state     <= START;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                START: begin
`ifdef WDOG_EN
                    wdog_cnt <= '0;
`endif
                    state <= COLLECT;
                end
                COLLECT: begin
                    if (col_valid) begin
                        rsp_mse   <= col_data;
                        rsp_pass  <= !col_data[63] && (col_data <= thr_q);
                        rsp_valid <= 1'b1;
`ifdef WDOG_EN
                        timeout_q <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef WDOG_EN
                    else if (wdog_cnt == WW'(TIMEOUT_CYC - 1)) begin
                        rsp_mse   <= '0;
                        rsp_pass  <= 1'b0;
                        timeout_q <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        run_cnt   <= run_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
